// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath mux selects and the packed control word driven by the decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_PC     = 2'b10
  } result_src_e;

  typedef struct packed {
    alu_op_e     alu_op;
    src_a_e      src_a;
    src_b_e      src_b;
    logic        pc_write;
    logic        pc_src;
    logic        ir_write;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    result_src_e result_src;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '{
    alu_op:     ALU_ADD,
    src_a:      SRC_A_PC,
    src_b:      SRC_B_RS2,
    pc_write:   1'b0,
    pc_src:     1'b0,
    ir_write:   1'b0,
    reg_write:  1'b0,
    mem_req:    1'b0,
    mem_we:     1'b0,
    iord:       1'b0,
    result_src: RES_ALUOUT
  };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decoder: current state plus instruction fields and status
// strobes to the control word and the nominal next state.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_word_t o_ctrl,
  output state_e     o_next_state
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    o_ctrl       = CTRL_IDLE;
    o_next_state = i_state;

    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.src_a   = SRC_A_PC;
        o_ctrl.src_b   = SRC_B_FOUR;
        o_ctrl.alu_op  = ALU_ADD;
        if (i_mem_ready) begin
          o_ctrl.ir_write = 1'b1;
          o_ctrl.pc_write = 1'b1;
          o_next_state    = S_DECODE;
        end
      end

      S_DECODE: begin
        o_ctrl.src_a = SRC_A_OLDPC;
        o_ctrl.src_b = SRC_B_IMM;
        case (i_opcode)
          OP_LOAD, OP_STORE: o_next_state = S_MEM_ADDR;
          OP_RTYPE:          o_next_state = S_EXEC_R;
          OP_ITYPE:          o_next_state = S_EXEC_I;
          OP_BRANCH:         o_next_state = S_BRANCH;
          OP_JAL:            o_next_state = S_JAL;
          default:           o_next_state = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        o_ctrl.src_a = SRC_A_RS1;
        o_ctrl.src_b = SRC_B_IMM;
        o_next_state = (i_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        if (i_mem_ready) o_next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_MEM;
        o_next_state      = S_FETCH;
      end

      S_MEM_WR: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.iord    = 1'b1;
        if (i_mem_ready) o_next_state = S_FETCH;
      end

      S_EXEC_R: begin
        o_ctrl.src_a  = SRC_A_RS1;
        o_ctrl.src_b  = SRC_B_RS2;
        o_ctrl.alu_op = ALU_RTYPE;
        o_next_state  = S_ALU_WB;
      end

      S_EXEC_I: begin
        o_ctrl.src_a  = SRC_A_RS1;
        o_ctrl.src_b  = SRC_B_IMM;
        o_ctrl.alu_op = ALU_ITYPE;
        o_next_state  = S_ALU_WB;
      end

      S_ALU_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_ALUOUT;
        o_next_state      = S_FETCH;
      end

      S_BRANCH: begin
        o_ctrl.src_a  = SRC_A_RS1;
        o_ctrl.src_b  = SRC_B_RS2;
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.pc_src = 1'b1;
        case (i_funct3)
          F3_BEQ: begin
            o_ctrl.pc_write = i_zero;
            o_next_state    = S_FETCH;
          end
          F3_BNE: begin
            o_ctrl.pc_write = !i_zero;
            o_next_state    = S_FETCH;
          end
          default: o_next_state = S_TRAP;
        endcase
      end

      S_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PC;
        o_next_state      = S_FETCH;
      end

      S_TRAP:  o_next_state = S_TRAP;
      // Unassigned state codes are treated as corruption and trapped.
      default: o_next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: state register, memory wait counter
// with optional timeout trap, sticky illegal flag and reset output gating.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_e           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_illegal;

  state_e           w_dec_next;
  state_e           w_next_state;
  ctrl_word_t       w_ctrl;
  ctrl_word_t       w_out;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_waiting;
  logic             w_timeout;

  ctrl_decode u_decode (
    .i_state      (r_state),
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_ctrl       (w_ctrl),
    .o_next_state (w_dec_next)
  );

  // A memory state that has not seen mem_ready is waiting; the counter only
  // runs then, so it is already zero whenever a memory state is entered.
  assign w_waiting = w_ctrl.mem_req && !mem_ready;
  assign w_cnt_inc = r_wait_cnt + CNT_W'(1);
  assign w_timeout = TIMEOUT_EN && w_waiting && (w_cnt_inc == TIMEOUT_CNT);

  always_comb begin
    w_next_state = w_timeout ? S_TRAP : w_dec_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= (TIMEOUT_EN && w_waiting) ? w_cnt_inc : '0;
      r_illegal  <= r_illegal || (w_next_state == S_TRAP);
    end
  end

  // Outputs are silenced for the whole cycle in which rst is asserted.
  always_comb begin
    w_out = rst ? CTRL_IDLE : w_ctrl;
  end

  assign alu_op     = w_out.alu_op;
  assign alu_src_a  = w_out.src_a;
  assign alu_src_b  = w_out.src_b;
  assign pc_write   = w_out.pc_write;
  assign pc_src     = w_out.pc_src;
  assign ir_write   = w_out.ir_write;
  assign reg_write  = w_out.reg_write;
  assign mem_req    = w_out.mem_req;
  assign mem_we     = w_out.mem_we;
  assign iord       = w_out.iord;
  assign result_src = w_out.result_src;
  assign illegal    = !rst && r_illegal;
  assign state_dbg  = rst ? 4'd0 : r_state;

endmodule
